// File: rtl/bus_regfile_pkg.sv
// Shared constants and helpers for the bus register file.
// Optional decrement support is enabled by defining BUS_REGFILE_DEC_EN.
package bus_regfile_pkg;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int ALU_A_IDX    = 0;
  localparam int ALU_B_IDX    = 1;

  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bus_regfile_if.sv
// Bus, handshake and status signals of bus_regfile grouped for port use.
// DEC_EN exists only when BUS_REGFILE_DEC_EN is defined.
interface bus_regfile_if
  import bus_regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS
);
  localparam int SELW = sel_w(NUM_REGS);

  logic [WIDTH-1:0]    BUS_IN;
  logic [WIDTH-1:0]    BUS_OUT;
  logic                BUS_DRIVE;
  logic                RD_EN;
  logic [SELW-1:0]     RD_SEL;
  logic                WR_EN;
  logic [SELW-1:0]     WR_SEL;
  logic [NUM_REGS-1:0] CNT_EN;
`ifdef BUS_REGFILE_DEC_EN
  logic [NUM_REGS-1:0] DEC_EN;
`endif
  logic [WIDTH-1:0]    ALU_A;
  logic [WIDTH-1:0]    ALU_B;
  logic [WIDTH-1:0]    OUT_DATA;
  logic                OUT_VALID;
  logic                OUT_READY;
  logic                SEL_ERR;
  logic                OUT_OVERRUN;

  modport slave (
`ifdef BUS_REGFILE_DEC_EN
    input  DEC_EN,
`endif
    input  BUS_IN, RD_EN, RD_SEL, WR_EN, WR_SEL, CNT_EN, OUT_READY,
    output BUS_OUT, BUS_DRIVE, ALU_A, ALU_B, OUT_DATA, OUT_VALID,
           SEL_ERR, OUT_OVERRUN
  );

  modport master (
`ifdef BUS_REGFILE_DEC_EN
    output DEC_EN,
`endif
    output BUS_IN, RD_EN, RD_SEL, WR_EN, WR_SEL, CNT_EN, OUT_READY,
    input  BUS_OUT, BUS_DRIVE, ALU_A, ALU_B, OUT_DATA, OUT_VALID,
           SEL_ERR, OUT_OVERRUN
  );
endinterface

// File: rtl/bus_reg_cell.sv
// One register: load has priority over count; with BUS_REGFILE_DEC_EN,
// simultaneous increment and decrement cancel out.
module bus_reg_cell #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_data_i,
  input  logic             inc_i,
`ifdef BUS_REGFILE_DEC_EN
  input  logic             dec_i,
`endif
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (ld_i) begin
      val_d = ld_data_i;
`ifdef BUS_REGFILE_DEC_EN
    end else if (inc_i && !dec_i) begin
      val_d = val_q + WIDTH'(1);
    end else if (dec_i && !inc_i) begin
      val_d = val_q - WIDTH'(1);
`else
    end else if (inc_i) begin
      val_d = val_q + WIDTH'(1);
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) val_q <= '0;
    else       val_q <= val_d;
  end

  assign q_o = val_q;
endmodule

// File: rtl/bus_regfile.sv
// Register file on a shared bus: combinational read, registered load/count,
// output-register handshake and sticky error flags. Macro: BUS_REGFILE_DEC_EN.
module bus_regfile
  import bus_regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int OUT_IDX  = NUM_REGS - 1
) (
  input  logic          CLK,
  input  logic          RST,
  bus_regfile_if.slave  bus
);
  localparam int              SELW    = sel_w(NUM_REGS);
  localparam logic [SELW:0]   NREGS   = (SELW+1)'(NUM_REGS);
  localparam logic [SELW-1:0] OUT_SEL = SELW'(OUT_IDX);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]               rd_data;
  logic rd_ok, wr_ok, wr_out;
  logic out_valid_q, out_valid_d;
  logic sel_err_q, sel_err_d;
  logic ovr_q, ovr_d;

  assign rd_ok  = {1'b0, bus.RD_SEL} < NREGS;
  assign wr_ok  = {1'b0, bus.WR_SEL} < NREGS;
  assign wr_out = bus.WR_EN && (bus.WR_SEL == OUT_SEL);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    logic ld;
    assign ld = bus.WR_EN && (bus.WR_SEL == SELW'(g));
    bus_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .clk_i     (CLK),
      .rst_i     (RST),
      .ld_i      (ld),
      .ld_data_i (bus.BUS_IN),
      .inc_i     (bus.CNT_EN[g]),
`ifdef BUS_REGFILE_DEC_EN
      .dec_i     (bus.DEC_EN[g]),
`endif
      .q_o       (regs[g])
    );
  end

  // Loop mux: out-of-range selects match no entry and read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (bus.RD_SEL == SELW'(i)) rd_data = regs[i];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ovr_d       = ovr_q;
    sel_err_d   = sel_err_q;
    if (wr_out) begin
      out_valid_d = 1'b1;
      if (out_valid_q && !bus.OUT_READY) ovr_d = 1'b1;
    end else if (out_valid_q && bus.OUT_READY) begin
      out_valid_d = 1'b0;
    end
    if ((bus.RD_EN && !rd_ok) || (bus.WR_EN && !wr_ok)) sel_err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.BUS_DRIVE   = bus.RD_EN;
  assign bus.BUS_OUT     = (bus.RD_EN && rd_ok) ? rd_data : '0;
  assign bus.ALU_A       = regs[ALU_A_IDX];
  assign bus.ALU_B       = regs[ALU_B_IDX];
  assign bus.OUT_DATA    = regs[OUT_IDX];
  assign bus.OUT_VALID   = out_valid_q;
  assign bus.SEL_ERR     = sel_err_q;
  assign bus.OUT_OVERRUN = ovr_q;
endmodule
